// File: rtl/alu_muldiv_if.sv
// Execute-stage ALU bus: operands, op select, start/busy/done handshake.
// master = controller side, slave = the ALU.
interface alu_muldiv_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [3:0]            op;
  logic                  start;
  logic [DATA_WIDTH-1:0] result;
  logic                  zero;
  logic                  overflow;
  logic                  busy;
  logic                  done;

  modport master (
    output a, b, op, start,
    input  result, zero, overflow, busy, done
  );

  modport slave (
    input  a, b, op, start,
    output result, zero, overflow, busy, done
  );
endinterface

// File: rtl/alu_muldiv.sv
// MIPS execute-stage ALU: single-cycle logic/arith ops plus an iterative
// multiply/divide unit with architectural HI/LO and start/busy/done.
module alu_muldiv #(
  parameter int DATA_WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  alu_muldiv_if.slave bus
);
  localparam int N  = DATA_WIDTH;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_TOP = CW'(N - 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MFHI  = 4'b1100;
  localparam logic [3:0] OP_MFLO  = 4'b1101;
  localparam logic [3:0] OP_MTHI  = 4'b1110;
  localparam logic [3:0] OP_MTLO  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  state_t        state;
  logic [N-1:0]  hi;
  logic [N-1:0]  lo;
  logic [N-1:0]  w_hi;
  logic [N-1:0]  w_lo;
  logic [N-1:0]  w_op;
  logic [N-1:0]  dvd;
  logic [CW-1:0] cnt;
  logic          neg_q;
  logic          neg_r;
  logic          dz;
  logic          is_div;
  logic          busy_q;
  logic          done_q;

  logic [N-1:0]  sum;
  logic [N-1:0]  diff;
  logic          ovf_add;
  logic          ovf_sub;

  assign sum     = bus.a + bus.b;
  assign diff    = bus.a - bus.b;
  assign ovf_add = (bus.a[N-1] == bus.b[N-1]) &&
                   (sum[N-1] != bus.a[N-1]);
  assign ovf_sub = (bus.a[N-1] != bus.b[N-1]) &&
                   (diff[N-1] != bus.a[N-1]);

  // Combinational result mux; MFHI/MFLO see only committed HI/LO.
  always_comb begin
    bus.result   = '0;
    bus.overflow = 1'b0;
    unique case (bus.op)
      OP_AND:  bus.result = bus.a & bus.b;
      OP_OR:   bus.result = bus.a | bus.b;
      OP_ADD: begin
        bus.result   = sum;
        bus.overflow = ovf_add;
      end
      OP_SUB: begin
        bus.result   = diff;
        bus.overflow = ovf_sub;
      end
      OP_SLT:  bus.result = N'(diff[N-1] ^ ovf_sub);
      OP_SLTU: bus.result = N'(bus.a < bus.b);
      OP_MFHI: bus.result = hi;
      OP_MFLO: bus.result = lo;
      default: bus.result = '0;
    endcase
  end

  assign bus.zero = (bus.result == '0);
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  logic          sgn;
  logic          launch;
  logic [N-1:0]  a_abs;
  logic [N-1:0]  b_abs;
  logic [N:0]    mul_sum;
  logic [N:0]    div_sh;
  logic [N:0]    div_df;
  logic [2*N-1:0] prod;
  logic [2*N-1:0] prod_s;
  logic [N-1:0]  q_s;
  logic [N-1:0]  r_s;

  assign sgn    = ~bus.op[0];
  assign launch = bus.start && (state == IDLE) &&
                  (bus.op[3:2] == 2'b10);
  assign a_abs  = (sgn && bus.a[N-1]) ? -bus.a : bus.a;
  assign b_abs  = (sgn && bus.b[N-1]) ? -bus.b : bus.b;

  // One shift-add / restoring-subtract step on the working regs.
  assign mul_sum = {1'b0, w_hi} +
                   (w_lo[0] ? {1'b0, w_op} : '0);
  assign div_sh  = {w_hi, w_lo[N-1]};
  assign div_df  = div_sh - {1'b0, w_op};

  // Sign fix-up of the magnitude result before commit.
  assign prod   = {w_hi, w_lo};
  assign prod_s = neg_q ? -prod : prod;
  assign q_s    = neg_q ? -w_lo : w_lo;
  assign r_s    = neg_r ? -w_hi : w_hi;

  // Mul/div sequencer, working regs and architectural HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      hi     <= '0;
      lo     <= '0;
      w_hi   <= '0;
      w_lo   <= '0;
      w_op   <= '0;
      dvd    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      is_div <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (launch) begin
            is_div <= bus.op[1];
            dvd    <= bus.a;
            dz     <= bus.op[1] && (bus.b == '0);
            neg_q  <= sgn && (bus.a[N-1] ^ bus.b[N-1]);
            neg_r  <= sgn && bus.a[N-1];
            cnt    <= CNT_TOP;
            w_hi   <= '0;
            busy_q <= 1'b1;
            if (bus.op[1]) begin
              w_lo  <= a_abs;
              w_op  <= b_abs;
              state <= DIV;
            end else begin
              w_lo  <= b_abs;
              w_op  <= a_abs;
              state <= MUL;
            end
          end else if (bus.start && bus.op == OP_MTHI) begin
            hi <= bus.a;
          end else if (bus.start && bus.op == OP_MTLO) begin
            lo <= bus.a;
          end
        end
        MUL: begin
          w_hi <= mul_sum[N:1];
          w_lo <= {mul_sum[0], w_lo[N-1:1]};
          cnt  <= cnt - CW'(1);
          if (cnt == '0) state <= FIX;
        end
        DIV: begin
          if (!div_df[N]) begin
            w_hi <= div_df[N-1:0];
            w_lo <= {w_lo[N-2:0], 1'b1};
          end else begin
            w_hi <= div_sh[N-1:0];
            w_lo <= {w_lo[N-2:0], 1'b0};
          end
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            hi <= prod_s[2*N-1:N];
            lo <= prod_s[N-1:0];
          end else if (dz) begin
            hi <= dvd;
            lo <= '1;
          end else begin
            hi <= r_s;
            lo <= q_s;
          end
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: stimulus pushes expectations,
// a negedge monitor pops and compares result/zero/overflow and busy length.
module tb_alu_muldiv;
  localparam int N = 32;
  localparam int LAT = N + 1;

  logic clk;
  logic reset;
  logic obs;

  alu_muldiv_if #(.DATA_WIDTH(N)) bus ();

  alu_muldiv #(.DATA_WIDTH(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  exp_t cq[$];
  int   dq[$];
  int   n_tests;
  int   n_fail;
  int   busy_cnt;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Monitor: comb observations and busy-run length per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_cnt = 0;
      dq.delete();
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (dq.size() == 0) chk("spurious_done", 32'd1, 32'd0);
        else chk("busy_len", busy_cnt, dq.pop_front());
        busy_cnt = 0;
      end
    end
    if (obs) begin
      if (cq.size() == 0) begin
        chk("empty_queue", 32'd1, 32'd0);
      end else begin
        e = cq.pop_front();
        chk(e.name, bus.result, e.res);
        chk({e.name, "_zero"}, 32'(bus.zero), 32'(e.res == 0));
        chk({e.name, "_ovf"}, 32'(bus.overflow), 32'(e.ovf));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic comb(string nm, logic [3:0] op, logic [31:0] a,
                      logic [31:0] b, logic [31:0] res, logic ovf);
    exp_t e;
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    e.name = nm;
    e.res  = res;
    e.ovf  = ovf;
    cq.push_back(e);
    obs = 1'b1;
    tick();
    obs = 1'b0;
  endtask

  task automatic launch(logic [3:0] op, logic [31:0] a,
                        logic [31:0] b);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    dq.push_back(LAT);
    tick();
    bus.start = 1'b0;
    bus.op    = 4'b0000;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic read_hilo(string nm, logic [31:0] h,
                           logic [31:0] l);
    comb({nm, "_hi"}, 4'b1100, 32'd0, 32'd0, h, 1'b0);
    comb({nm, "_lo"}, 4'b1101, 32'd0, 32'd0, l, 1'b0);
  endtask

  initial begin
    int dcnt;
    n_tests   = 0;
    n_fail    = 0;
    busy_cnt  = 0;
    obs       = 1'b0;
    reset     = 1'b1;
    bus.a     = '0;
    bus.b     = '0;
    bus.op    = '0;
    bus.start = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    tick();
    comb("rst_mflo", 4'b1101, 32'd5, 32'd6, 32'd0, 1'b0);
    reset = 1'b0;
    tick();

    comb("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1);
    comb("slt_neg", 4'b0111, 32'h8000_0000, 32'd1, 32'd1, 1'b0);
    comb("sltu", 4'b0011, 32'h8000_0000, 32'd1, 32'd0, 1'b0);
    comb("sub_zero", 4'b0110, 32'd5, 32'd5, 32'd0, 1'b0);
    comb("sub_ovf", 4'b0110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1);
    comb("slt_ovf0", 4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    comb("slt_ovf1", 4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0);
    comb("and", 4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0);
    comb("or", 4'b0001, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0);
    comb("undef", 4'b0100, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);

    launch(4'b1000, 32'hFFFF_FFFD, 32'd5);
    wait_done();
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    launch(4'b1001, 32'hFFFF_FFFF, 32'd2);
    wait_done();
    read_hilo("multu", 32'd1, 32'hFFFF_FFFE);

    launch(4'b1010, 32'hFFFF_FFF9, 32'd2);
    wait_done();
    read_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    launch(4'b1011, 32'd100, 32'd7);
    wait_done();
    read_hilo("divu", 32'd2, 32'd14);

    launch(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();
    read_hilo("div_min", 32'd0, 32'h8000_0000);

    launch(4'b1011, 32'd9, 32'd0);
    comb("mflo_busy", 4'b1101, 32'd0, 32'd0, 32'h8000_0000, 1'b0);
    wait_done();
    read_hilo("divz", 32'd9, 32'hFFFF_FFFF);

    launch(4'b1000, 32'h0001_0000, 32'h0001_0000);
    tick();
    bus.op    = 4'b1110;
    bus.a     = 32'h1234;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.op    = 4'b1100;
    wait_done();
    chk("hi_at_done", bus.result, 32'd1);
    bus.op    = 4'b1011;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    bus.start = 1'b1;
    dq.push_back(LAT);
    tick();
    bus.start = 1'b0;
    @(negedge clk);
    chk("busy_after_done", 32'(bus.busy), 32'd1);
    wait_done();
    read_hilo("b2b_divu", 32'd2, 32'd14);

    bus.op    = 4'b1111;
    bus.a     = 32'hAA;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    comb("mtlo", 4'b1101, 32'd0, 32'd0, 32'hAA, 1'b0);
    launch(4'b1000, 32'd3, 32'd4);
    repeat (9) tick();
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    tick();
    reset = 1'b0;
    read_hilo("abort", 32'd0, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("no_done_after_rst", dcnt, 32'd0);
    tick();
    launch(4'b1000, 32'd6, 32'd7);
    wait_done();
    read_hilo("mult_after_rst", 32'd0, 32'd42);

    repeat (2) tick();
    if (cq.size() != 0 || dq.size() != 0)
      chk("queues_drained", 32'(cq.size() + dq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
